// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM encodings, data width
// and the address range check used by the multi-cycle CPU data port.
package data_mem_responder_pkg;

    localparam int DM_DATA_W = 32;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // True when every address bit above the array index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int aw);
        return ((addr >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/data_mem_responder_sram.sv
// Single-port synchronous RAM backing the data-memory responder.
// Registered read; read-during-write returns the old word.
module dm_sram_array
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DM_DATA_W-1:0] din,
    output logic [DM_DATA_W-1:0] dout
);

    logic [DM_DATA_W-1:0] mem_r [2**ADDR_W];
    logic [DM_DATA_W-1:0] dout_r;

    // Array write and registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= din;
        end
        dout_r <= mem_r[addr];
    end

    assign dout = dout_r;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port: one outstanding load/store,
// valid/ready handshakes, programmable wait states before the array access.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]           state_r;
    logic [3:0]           cnt_r;
    logic                 we_r;
    logic [31:0]          addr_r;
    logic [DM_DATA_W-1:0] wdata_r;
    logic                 req_ready_r;
    logic                 rsp_valid_r;
    logic [31:0]          rsp_rdata_r;
    logic                 rsp_err_r;

    logic                 in_range_s;
    logic                 sram_we_s;
    logic [ADDR_W-1:0]    sram_addr_s;
    logic [DM_DATA_W-1:0] sram_dout_s;

    assign in_range_s = addr_in_range(addr_r, ADDR_W);

    // RAM controls: read the incoming address while idle so the word is ready
    // by the ACCESS edge even with zero wait states; reset blocks the write.
    always_comb begin
        sram_we_s   = 1'b0;
        sram_addr_s = addr_r[ADDR_W-1:0];
        if (state_r == ST_IDLE) begin
            sram_addr_s = req_addr[ADDR_W-1:0];
        end else begin
            sram_addr_s = addr_r[ADDR_W-1:0];
        end
        if (rst && (state_r == ST_ACCESS) && we_r && in_range_s) begin
            sram_we_s = 1'b1;
        end else begin
            sram_we_s = 1'b0;
        end
    end

    dm_sram_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk  (clk),
        .we   (sram_we_s),
        .addr (sram_addr_s),
        .din  (wdata_r),
        .dout (sram_dout_s)
    );

    // Transaction FSM, wait counter, request latch and response registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            we_r        <= 1'b0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid && req_ready_r) begin
                        we_r        <= req_we;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        cnt_r       <= 4'd0;
                        req_ready_r <= 1'b0;
                        state_r     <= (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == WAIT_LAST) begin
                        cnt_r   <= 4'd0;
                        state_r <= ST_ACCESS;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    rsp_err_r   <= ~in_range_s;
                    rsp_rdata_r <= (!we_r && in_range_s) ? sram_dout_s : 32'd0;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b1;
                    rsp_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (WAIT_CYCLES=2 and a
// zero-wait instance for the throughput/latency case).
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_we, z_rsp_ready;
    logic [31:0] z_req_addr, z_req_wdata;
    logic        z_req_ready, z_rsp_valid, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(6), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_W(6), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // One full transaction with rsp_ready held high; lat = edges from accept to rsp_valid.
    task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
        req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0; req_we = ~we;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata; er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", rsp_rdata); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat;
        xfer(1'b1, 32'd5, 32'hDEADBEEF, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL store_rdata got %h want 0", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL store_err got %b want 0", er); end
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL store_done got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
        xfer(1'b0, 32'd5, 32'h0, rd, er, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d want 3", lat); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL load_err got %b want 0", er); end
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'd5; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = 32'd9;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 3) begin errors++; $display("FAIL bp_latency got %0d want 3", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid cyc %0d got %b want 1", i, rsp_valid); end
            checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_hold_rdata cyc %0d got %h want deadbeef", i, rsp_rdata); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", req_ready); end
        checks++; if (rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL bp_retain_rdata got %h want deadbeef", rsp_rdata); end
        @(posedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_idle_ready_ignored got %b want 0", rsp_valid); end
        rsp_ready = 1'b1;
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        xfer(1'b1, 32'd0, 32'h0BADF00D, rd, er, lat);
        xfer(1'b1, 32'h40, 32'd1, rd, er, lat);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL oor_store_err got %b want 1", er); end
        checks++; if (lat !== 3) begin errors++; $display("FAIL oor_latency got %0d want 3", lat); end
        xfer(1'b0, 32'h8000_0000, 32'h0, rd, er, lat);
        checks++; if (er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL oor_load got err=%b data=%h want 1/0", er, rd); end
        xfer(1'b0, 32'd0, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL oor_alias_load got %h want 0badf00d", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL oor_alias_err got %b want 0", er); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        xfer(1'b1, 32'd7, 32'h5555AAAA, rd, er, lat);
        req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
        xfer(1'b0, 32'd7, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL midrst_wait_load got %h want 5555aaaa", rd); end
        // Reset sampled at the ACCESS edge must block the store.
        req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h9999; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_access_valid got %b want 0", rsp_valid); end
        xfer(1'b0, 32'd7, 32'h0, rd, er, lat);
        checks++; if (rd !== 32'h5555AAAA) begin errors++; $display("FAIL midrst_access_load got %h want 5555aaaa", rd); end
    endtask

    task automatic test_back_to_back();
        int last_acc;
        int nacc;
        int lat;
        logic prev_v;
        z_req_we = 1'b1; z_req_addr = 32'd3; z_req_wdata = 32'hCAFE0003; z_req_valid = 1'b1;
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        lat = 0;
        while (z_rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL zw_store_latency got %0d want 1", lat); end
        @(posedge clk); #1;
        z_req_we = 1'b0; z_req_addr = 32'd3; z_req_valid = 1'b1;
        last_acc = -1; nacc = 0; prev_v = 1'b0;
        for (int t = 0; t < 15; t++) begin
            if (z_rsp_valid === 1'b1 && prev_v === 1'b0) begin
                checks++; if (t - last_acc !== 1) begin errors++; $display("FAIL zw_latency at %0d got %0d want 1", t, t - last_acc); end
                checks++; if (z_rsp_rdata !== 32'hCAFE0003) begin errors++; $display("FAIL zw_rdata got %h want cafe0003", z_rsp_rdata); end
            end
            prev_v = z_rsp_valid;
            if (z_req_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    checks++; if ((t + 1) - last_acc !== 3) begin
                        errors++; $display("FAIL zw_accept_gap got %0d want 3", (t + 1) - last_acc); end
                end
                last_acc = t + 1;
                nacc++;
            end
            @(posedge clk); #1;
        end
        z_req_valid = 1'b0;
        checks++; if (nacc !== 5) begin errors++; $display("FAIL zw_accept_count got %0d want 5", nacc); end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = 32'd0; z_req_wdata = 32'd0; z_rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_backpressure();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
